irq_priority_sequencer: RTL
===========================

# irq_priority_sequencer

Priority and nesting sequencer placed behind the APB interrupt controller. It takes the controller's 32 masked, active-high status lines and assigns each source one of four priority levels. It tracks in-service levels so that only strictly higher-priority interrupts preempt, and drives a single vectored interrupt to the processor with an acknowledge (vector read) and end-of-interrupt (EOI write) handshake over APB.

## Interface
- NUMSRC, 32: number of sources used, range 1..32; status bits at or above NUMSRC are ignored and their PRIO fields read 0.
- PCLK in 1: APB clock; single clock domain.
- PRESETn in 1: reset, asynchronous and active-low.
- PSEL in 1: APB select.
- PENABLE in 1: APB enable.
- PWRITE in 1: APB write.
- PADDR in [5:2]: APB word address.
- PWDATA in 32: APB write data.
- PRDATA out 32: APB read data, registered.
- irqStatus in 32: per-source pending, active high, synchronous to PCLK.
- IRQ out 1: vectored interrupt request, active high, registered.

## Operation
- Register map (PADDR):
  - 0 VECTOR, RO, acknowledge on read: bit31 valid, [9:8] level, [4:0] source id.
  - 1 EOI, WO: data ignored.
  - 2 PRIO0, RW: source i (0..15) level in bits [2i+1:2i].
  - 3 PRIO1, RW: sources 16..31, same packing.
  - 4 INSERVICE, RO: [3:0] in-service level bits.
  - Other addresses: read 0, writes ignored.
- Write strobe is PSEL & PWRITE & !PENABLE. Read capture and read side effects occur on PSEL & !PWRITE & !PENABLE.
- Level 3 is highest.
- Running level R is the highest set INSERVICE bit; with INSERVICE = 0 it is none.
- A source is eligible when irqStatus[i] = 1, i < NUMSRC, and its level > R. Any level is eligible when R is none.
- Winner: highest eligible level; on a tie, the lowest id.
- The candidate register {cand_valid, cand_lvl, cand_id} reloads from the winner every cycle. IRQ = cand_valid.
- VECTOR read with cand_valid = 1:
  - returns the candidate;
  - sets INSERVICE[cand_lvl];
  - the same source and all sources at or below that level stop being eligible.
- VECTOR read with cand_valid = 0 returns 0 and has no side effect (spurious).
- EOI write clears the highest set INSERVICE bit. EOI with INSERVICE = 0 has no effect.
- Nesting is capped at 4 levels, one per level. A level cannot be re-entered until its EOI.
- A PRIO write does not alter INSERVICE. The new level takes effect on the next candidate evaluation.

## Timing
- Reset values: PRDATA 0, IRQ 0, candidate 0, PRIO0/PRIO1 0, INSERVICE 0.
- irqStatus rises and is sampled at edge n: IRQ is high after edge n.
- Source deasserts before acknowledge: IRQ falls one edge after irqStatus falls. A VECTOR read after that returns valid = 0.
- VECTOR read: PRDATA and INSERVICE both update on the setup-phase edge (edge s). PRDATA holds through the access phase. PRDATA returns to 0 at the next non-read-setup edge.
- After acknowledge: IRQ falls at edge s+1 unless a strictly higher level is pending. In that case IRQ stays high and the candidate changes at s+1.
- EOI at edge e: the INSERVICE update is visible at e. Re-eligible sources raise IRQ at edge e+1.
- Simultaneous events:
  - An irqStatus change in the same cycle as a VECTOR read does not affect the returned value, which is the registered candidate.
  - The acknowledge and the candidate reload at the same edge use the pre-acknowledge INSERVICE. The next edge corrects the candidate.
- PRESETn low mid-transaction clears everything immediately, with asynchronous assertion. All state resumes from reset values.

## Structure
- Shared package irq_seq_pkg:
  - address constants VECTORA, EOIA, PRIO0A, PRIO1A, INSERVICEA;
  - LVLW = 2, NUMLVL = 4;
  - vector field positions (valid 31, level 9:8, id 4:0).
- One combinational sub-module, irq_prio_pick. Inputs: 32 status bits, 64 priority bits, running level. Outputs: valid, level, id. It contains the level-first, lowest-id tie-break tree.
- Top level holds the APB decode, PRIO/INSERVICE registers, candidate register, and PRDATA register.

## Test plan
- Reset → PRDATA 0, IRQ 0, INSERVICE reads 0, VECTOR read returns 0x00000000.
- Sources 5 and 9 at level 1, both raised → VECTOR reads 0x80000105; INSERVICE = 0x2; IRQ low one cycle later.
- Nesting:
  - In service at level 1, source 20 at level 3 raised → IRQ high; VECTOR reads 0x80000314; INSERVICE = 0xA.
  - EOI → INSERVICE = 0x2.
  - EOI → INSERVICE = 0x0.
- Same-level block: in service at level 2, another level-2 source raised → IRQ stays low. After EOI, IRQ rises one edge later.
- Spurious read: source 3 raised then dropped before the read → VECTOR reads 0x0; INSERVICE unchanged. A further EOI with INSERVICE = 0 has no effect.
- NUMSRC = 8:
  - irqStatus = 0x100 → IRQ stays 0.
  - Write PRIO0 = 0xFFFFFFFF → reads back 0x0000FFFF.

Source files
------------

// File: rtl/irq_seq_pkg.sv
// Shared constants, types and helpers for the interrupt priority sequencer.
package irq_seq_pkg;

    // APB word addresses (PADDR[5:2])
    localparam logic [3:0] VECTORA    = 4'd0;
    localparam logic [3:0] EOIA       = 4'd1;
    localparam logic [3:0] PRIO0A     = 4'd2;
    localparam logic [3:0] PRIO1A     = 4'd3;
    localparam logic [3:0] INSERVICEA = 4'd4;

    localparam int unsigned LVLW   = 2;
    localparam int unsigned NUMLVL = 4;

    // VECTOR register field positions
    localparam int unsigned VEC_VALID  = 31;
    localparam int unsigned VEC_LVL_HI = 9;
    localparam int unsigned VEC_LVL_LO = 8;
    localparam int unsigned VEC_ID_HI  = 4;
    localparam int unsigned VEC_ID_LO  = 0;

    typedef struct packed {
        logic            valid;
        logic [LVLW-1:0] lvl;
        logic [4:0]      id;
    } cand_t;

    // One bit per implemented source.
    function automatic logic [31:0] srcMask(input int unsigned n);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

    // Two PRIO bits per implemented source.
    function automatic logic [63:0] prioMask(input int unsigned n);
        logic [63:0] m;
        m = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            m[2*i +: 2] = {2{i < n}};
        end
        return m;
    endfunction

    // Index of the highest set in-service bit (only meaningful when any bit is set).
    function automatic logic [LVLW-1:0] runLevel(input logic [NUMLVL-1:0] inSvc);
        logic [LVLW-1:0] l;
        l = '0;
        for (int unsigned i = 0; i < NUMLVL; i++) begin
            if (inSvc[i]) begin
                l = LVLW'(i);
            end
        end
        return l;
    endfunction

    // One-hot of the highest set in-service bit, zero when none.
    function automatic logic [NUMLVL-1:0] topBit(input logic [NUMLVL-1:0] inSvc);
        logic [NUMLVL-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < NUMLVL; i++) begin
            if (inSvc[i]) begin
                t = '0;
                t[i] = 1'b1;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/irq_prio_pick.sv
// Combinational winner selection: highest eligible level, lowest id on ties.
module irq_prio_pick
    import irq_seq_pkg::*;
(
    input  logic [31:0]     status,
    input  logic [63:0]     prio,
    input  logic            runActive,
    input  logic [LVLW-1:0] runLvl,
    output logic            valid,
    output logic [LVLW-1:0] lvl,
    output logic [4:0]      id
);

    // Heap-indexed tree: leaves 32..63 hold sources 0..31, node n merges 2n and 2n+1.
    logic            nodeV [64];
    logic [LVLW-1:0] nodeL [64];
    logic [4:0]      nodeI [64];

    // Build leaves from eligibility, then reduce pairwise; left child (lower ids) wins ties.
    always_comb begin
        for (int unsigned n = 0; n < 64; n++) begin
            nodeV[n] = 1'b0;
            nodeL[n] = '0;
            nodeI[n] = '0;
        end
        for (int unsigned i = 0; i < 32; i++) begin
            nodeL[32+i] = prio[2*i +: 2];
            nodeI[32+i] = 5'(i);
            nodeV[32+i] = status[i] && (!runActive || (prio[2*i +: 2] > runLvl));
        end
        for (int unsigned n = 31; n >= 1; n--) begin
            if (nodeV[2*n+1] && (!nodeV[2*n] || (nodeL[2*n+1] > nodeL[2*n]))) begin
                nodeV[n] = 1'b1;
                nodeL[n] = nodeL[2*n+1];
                nodeI[n] = nodeI[2*n+1];
            end else begin
                nodeV[n] = nodeV[2*n];
                nodeL[n] = nodeL[2*n];
                nodeI[n] = nodeI[2*n];
            end
        end
        valid = nodeV[1];
        lvl   = nodeL[1];
        id    = nodeI[1];
    end

endmodule

// File: rtl/irq_priority_sequencer.sv
// Priority/nesting sequencer: APB registers, in-service tracking, vectored IRQ.
module irq_priority_sequencer
    import irq_seq_pkg::*;
#(
    parameter int unsigned NUMSRC = 32
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [5:2]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    input  logic [31:0] irqStatus,
    output logic        IRQ
);

    localparam logic [31:0] SRCMASK  = srcMask(NUMSRC);
    localparam logic [63:0] PRIOMASK = prioMask(NUMSRC);

    logic [63:0]       prio;
    logic [NUMLVL-1:0] inService;
    cand_t             cand;
    cand_t             pick;
    logic [31:0]       rdData;
    logic              wrStrobe;
    logic              rdStrobe;
    logic              vecAck;
    logic              eoiWr;

    assign wrStrobe = PSEL & PWRITE & ~PENABLE;
    assign rdStrobe = PSEL & ~PWRITE & ~PENABLE;
    assign vecAck   = rdStrobe && (PADDR == VECTORA) && cand.valid;
    assign eoiWr    = wrStrobe && (PADDR == EOIA);
    assign IRQ      = cand.valid;

    irq_prio_pick u_pick (
        .status    (irqStatus & SRCMASK),
        .prio      (prio),
        .runActive (|inService),
        .runLvl    (runLevel(inService)),
        .valid     (pick.valid),
        .lvl       (pick.lvl),
        .id        (pick.id)
    );

    // Read data mux; VECTOR presents the registered candidate, not the live winner.
    always_comb begin
        rdData = '0;
        case (PADDR)
            VECTORA: begin
                if (cand.valid) begin
                    rdData[VEC_VALID]               = 1'b1;
                    rdData[VEC_LVL_HI:VEC_LVL_LO]   = cand.lvl;
                    rdData[VEC_ID_HI:VEC_ID_LO]     = cand.id;
                end
            end
            PRIO0A:     rdData = prio[31:0];
            PRIO1A:     rdData = prio[63:32];
            INSERVICEA: rdData[NUMLVL-1:0] = inService;
            default:    rdData = '0;
        endcase
    end

    // Priority registers; fields of unimplemented sources stay zero.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            prio <= '0;
        end else if (wrStrobe && (PADDR == PRIO0A)) begin
            prio[31:0] <= PWDATA & PRIOMASK[31:0];
        end else if (wrStrobe && (PADDR == PRIO1A)) begin
            prio[63:32] <= PWDATA & PRIOMASK[63:32];
        end
    end

    // In-service levels: acknowledge sets the candidate's level, EOI clears the highest.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            inService <= '0;
        end else if (vecAck) begin
            inService[cand.lvl] <= 1'b1;
        end else if (eoiWr) begin
            inService <= inService & ~topBit(inService);
        end
    end

    // Candidate reloads every cycle from the current in-service state; an acknowledge
    // on the same edge is therefore seen by the picker one edge later.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cand <= '0;
        end else begin
            cand <= pick;
        end
    end

    // PRDATA captured on the read setup edge, zero on any other edge.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PRDATA <= '0;
        end else if (rdStrobe) begin
            PRDATA <= rdData;
        end else begin
            PRDATA <= '0;
        end
    end

endmodule
